// File: rtl/ms_4bit_serial_if.sv
// ms_4bit_serial_if: operand/result bundle for the bit-serial 4-bit subtractor
interface ms_4bit_serial_if;
  logic start;
  logic [3:0] a;
  logic [3:0] b;
  logic bin;
  logic busy;
  logic done;
  logic [3:0] d;
  logic bout;
  modport master(output start, a, b, bin, input busy, done, d, bout);
  modport slave(input start, a, b, bin, output busy, done, d, bout);
endinterface

// File: rtl/ms_4bit_serial.sv
// ms_4bit_serial: 4-bit subtractor computing a-b-bin LSB first through one full-subtractor cell
module ms_4bit_serial (
  input logic clk,
  input logic rst,
  ms_4bit_serial_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] ra, rb, res, d_q;
  logic [1:0] cnt;
  logic br, bout_q;
  logic accept, ai, bi, di, br_nxt, last;
  always_comb begin
    ai = ra[cnt];
    bi = rb[cnt];
    di = ai ^ bi ^ br;
    br_nxt = (~ai & bi) | (~(ai ^ bi) & br);
    last = cnt == 2'd3;
    accept = bus.start && state != SHIFT;
    state_nxt = (state == SHIFT) ? (last ? DONE : SHIFT) : (bus.start ? SHIFT : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // d/bout only change on the final bit so partial results never show
  always_ff @(posedge clk) begin
    if (rst) begin
      ra <= '0;
      rb <= '0;
      res <= '0;
      br <= 1'b0;
      cnt <= '0;
      d_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      ra <= bus.a;
      rb <= bus.b;
      br <= bus.bin;
      cnt <= '0;
    end else if (state == SHIFT) begin
      res <= {di, res[3:1]};
      br <= br_nxt;
      cnt <= cnt + 2'd1;
      if (last) begin
        d_q <= {di, res[3:1]};
        bout_q <= br_nxt;
      end
    end
  end
  assign bus.busy = state == SHIFT;
  assign bus.done = state == DONE;
  assign bus.d = d_q;
  assign bus.bout = bout_q;
endmodule

// File: doc/ms_4bit_serial.md
MS_4BIT_SERIAL -- requirements
Module: ms_4bit_serial

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 4 bits.
REQ-002 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 RST  input  1  synchronous reset, active-high, sampled on the CLK rising edge.
REQ-004 Start  input  1  request to begin a subtraction; one-cycle pulse or level.
REQ-005 A  input  4  minuend; sampled only on the edge that accepts Start.
REQ-006 B  input  4  subtrahend; sampled only on the edge that accepts Start.
REQ-007 Bin  input  1  borrow-in; sampled only on the edge that accepts Start.
REQ-008 Busy  output  1  high while bits are being processed.
REQ-009 Done  output  1  one-cycle pulse when D and Bout carry a new result.
REQ-010 D  output  4  difference, A - B - Bin modulo 16.
REQ-011 Bout  output  1  borrow-out; 1 when A < B + Bin.

Function
REQ-012 Block SHALL compute D and Bout bit-serially, LSB first, one bit per CLK cycle, using a single 1-bit full-subtractor cell and a borrow register.
REQ-013 Bit rule SHALL be d_i = a_i ^ b_i ^ br, and br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-014 FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-015 IDLE to SHIFT: when Start=1, the block SHALL latch A, B and Bin into internal registers, set the borrow register to Bin and clear the bit counter to 0.
REQ-016 In SHIFT, each edge SHALL process bit[cnt], shift the result bit into the internal result register, update the borrow register and increment cnt.
REQ-017 SHIFT to DONE SHALL occur on the edge that processes cnt=3; on the same edge, D SHALL load the full 4-bit result and Bout SHALL load the final borrow.
REQ-018 DONE: Done=1 for exactly one cycle; on the next edge the FSM SHALL go to SHIFT if Start=1 (new operands latched per REQ-015), else to IDLE.
REQ-019 Latency: if Start is accepted on edge k, Done SHALL be high in the cycle after edge k+4, and Busy SHALL be high in the cycles after edges k through k+3.
REQ-020 Busy SHALL be 1 only in SHIFT; Done SHALL be 1 only in DONE; Busy and Done SHALL never both be 1.
REQ-021 Start SHALL be ignored while in SHIFT; inputs changing during SHIFT SHALL NOT affect the result in progress.
REQ-022 D and Bout SHALL hold the last completed result until the next transition into DONE; they SHALL NOT show partial results.
REQ-023 Wrap-around: the result SHALL be modulo 16, with Bout as the only indication of underflow; no saturation.
REQ-024 The bit counter SHALL be 2 bits and SHALL NOT be used outside SHIFT.

Reset
REQ-025 With RST=1 on an edge, the block SHALL set state=IDLE, Busy=0, Done=0, D=4'b0000, Bout=0, and clear cnt, the borrow register and the operand registers.
REQ-026 RST SHALL take priority over Start and over any in-progress operation; a reset during SHIFT SHALL abort it with no Done pulse.
REQ-027 Start=1 on the reset edge SHALL be ignored; the first acceptance SHALL be on the first edge with RST=0.

Verification
REQ-028 A=9, B=3, Bin=0, Start pulse -> Busy high 4 cycles, then Done pulse with D=6, Bout=0.
REQ-029 A=3, B=9, Bin=0 -> D=10 (4'hA), Bout=1; A=0, B=0, Bin=1 -> D=15, Bout=1; A=15, B=15, Bin=0 -> D=0, Bout=0.
REQ-030 Start at A=9/B=3, re-assert Start with A=1/B=2 during SHIFT -> second Start ignored; Done with D=6 only; D held at 6 through the following IDLE.
REQ-031 Start held high continuously with A=5/B=4 -> back-to-back results every 5 cycles, D=1, Bout=0, with no extra IDLE cycle between operations.
REQ-032 RST asserted 2 cycles after Start -> next cycle Busy=0, Done=0, D=0, Bout=0, and no Done pulse follows.
REQ-033 Exhaustive sweep of all 512 (A, B, Bin) combinations -> D == (A-B-Bin) mod 16 and Bout == (A < B+Bin) for every case, with the REQ-019 latency each time.
